// File: rtl/gearbox_pkg.sv
// Shared definitions for the N-to-M gearbox.
//   gb_state_e : control FSM states (IDLE, FLUSH)
//   clog2      : constant-foldable ceiling log2, used to size the fill counter
package gearbox_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } gb_state_e;

    // Smallest width w with 2**w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/gearbox_n_to_m_if.sv
// Handshake bundle of the N-to-M gearbox.
//   din/din_valid/din_ready          : input word stream, bit 0 oldest
//   flush/flush_busy                 : drain request and its in-progress flag
//   dout/dout_valid/dout_ready/dout_last : output word stream, bit 0 oldest
//   fill_level                       : number of valid bits held in the buffer
// Modport slave is the gearbox itself; master is the side that feeds and drains it.
interface gearbox_n_to_m_if
    import gearbox_pkg::*;
#(
    parameter int unsigned DIN_W  = 132,
    parameter int unsigned DOUT_W = 128
);
    localparam int unsigned BUF_W  = DIN_W + DOUT_W;
    localparam int unsigned FILL_W = clog2(BUF_W + 1);

    logic [DIN_W-1:0]  din;
    logic              din_valid;
    logic              din_ready;
    logic              flush;
    logic              flush_busy;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic [FILL_W-1:0] fill_level;

    modport master (
        output din, din_valid, flush, dout_ready,
        input  din_ready, flush_busy, dout, dout_valid, dout_last, fill_level
    );

    modport slave (
        input  din, din_valid, flush, dout_ready,
        output din_ready, flush_busy, dout, dout_valid, dout_last, fill_level
    );

endinterface

// File: rtl/gearbox_shift_buf.sv
// Bit buffer datapath of the gearbox: BUF_W-bit register whose valid bits sit in
// buf_q[fill-1:0] with the oldest bit at 0, plus its fill counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   din, push  : word to append above the current (post-pop) fill
//   pop        : drop the lowest DOUT_W bits (or all bits if fewer are held)
//   dout       : lowest DOUT_W bits of the buffer
//   fill       : current fill; fill_next : fill after this cycle's pop/push
module gearbox_shift_buf
    import gearbox_pkg::*;
#(
    parameter int unsigned DIN_W  = 132,
    parameter int unsigned DOUT_W = 128,
    localparam int unsigned BUF_W  = DIN_W + DOUT_W,
    localparam int unsigned FILL_W = clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  din,
    input  logic              push,
    input  logic              pop,
    output logic [DOUT_W-1:0] dout,
    output logic [FILL_W-1:0] fill,
    output logic [FILL_W-1:0] fill_next
);

    localparam logic [FILL_W-1:0] DOUT_FILL = FILL_W'(DOUT_W);
    localparam logic [FILL_W-1:0] DIN_FILL  = FILL_W'(DIN_W);

    logic [BUF_W-1:0]  buf_q, buf_d, buf_shifted;
    logic [FILL_W-1:0] fill_q, fill_d, fill_shifted, pop_cnt;

    always_comb begin
        pop_cnt      = (fill_q >= DOUT_FILL) ? DOUT_FILL : fill_q;
        // Right shift feeds zeros in at the top, which keeps every bit above
        // fill at 0 so a partial output word comes out zero-padded.
        buf_shifted  = pop ? (buf_q >> DOUT_W) : buf_q;
        fill_shifted = pop ? (fill_q - pop_cnt) : fill_q;
        buf_d        = buf_shifted;
        fill_d       = fill_shifted;
        if (push) begin
            // Insert lands just above whatever survives this cycle's pop.
            buf_d  = buf_shifted | (BUF_W'(din) << fill_shifted);
            fill_d = fill_shifted + DIN_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign dout      = buf_q[DOUT_W-1:0];
    assign fill      = fill_q;
    assign fill_next = fill_d;

endmodule

// File: rtl/gearbox_n_to_m.sv
// N-to-M width gearbox: repacks a stream of DIN_W-bit words into DOUT_W-bit
// words, bit 0 oldest on both sides, with a flush that drains the residue as a
// final zero-padded word marked dout_last.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gearbox_n_to_m_if.slave (din/dout handshakes, flush, fill_level)
// Holds the IDLE/FLUSH FSM and the handshake decode; the buffer lives in
// gearbox_shift_buf.
module gearbox_n_to_m
    import gearbox_pkg::*;
#(
    parameter int unsigned DIN_W  = 132,
    parameter int unsigned DOUT_W = 128
) (
    input logic             clk,
    input logic             rst_n,
    gearbox_n_to_m_if.slave bus
);

    localparam int unsigned       BUF_W     = DIN_W + DOUT_W;
    localparam int unsigned       FILL_W    = clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] DOUT_FILL = FILL_W'(DOUT_W);

    gb_state_e         state_q;
    logic [FILL_W-1:0] fill, fill_next;
    logic [DOUT_W-1:0] dout_word;
    logic              din_ready, dout_valid, dout_last, push, pop;

    // All handshake outputs decode registered state only; din_ready never
    // depends on dout_ready or din_valid.
    always_comb begin
        din_ready  = (state_q == IDLE) && (fill <= DOUT_FILL);
        dout_valid = (fill >= DOUT_FILL) || ((state_q == FLUSH) && (fill != '0));
        dout_last  = (state_q == FLUSH) && (fill != '0) && (fill <= DOUT_FILL);
        push       = bus.din_valid && din_ready;
        pop        = dout_valid && bus.dout_ready;
    end

    gearbox_shift_buf #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W)
    ) u_shift_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (bus.din),
        .push      (push),
        .pop       (pop),
        .dout      (dout_word),
        .fill      (fill),
        .fill_next (fill_next)
    );

    // The FLUSH decision looks at the fill after this cycle's push and pop, so
    // a same-cycle push is covered by the flush, and a flush that coincides
    // with the pop that empties the buffer cannot strand the FSM in FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush && (fill_next != '0)) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // flush requests are ignored here; leave once drained.
                    if (fill_next == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.dout       = dout_word;
    assign bus.dout_valid = dout_valid;
    assign bus.dout_last  = dout_last;
    assign bus.flush_busy = (state_q == FLUSH);
    assign bus.fill_level = fill;

endmodule
